// File: rtl/jpeg_pkg.sv
// Shared JPEG quantization constants: Annex K tables in zigzag order, the
// reciprocal helper and the run-length symbol record.
package jpeg_pkg;

  localparam int BLOCK_SIZE  = 64;
  localparam int RECIP_SHIFT = 16;
  localparam int SYM_VALUE_W = 16;

  localparam logic [7:0] Q_LUMA [BLOCK_SIZE] = '{
    8'd16,  8'd11,  8'd12,  8'd14,  8'd12,  8'd10,  8'd16,  8'd14,
    8'd13,  8'd14,  8'd18,  8'd17,  8'd16,  8'd19,  8'd24,  8'd40,
    8'd26,  8'd24,  8'd22,  8'd22,  8'd24,  8'd49,  8'd35,  8'd37,
    8'd29,  8'd40,  8'd58,  8'd51,  8'd61,  8'd60,  8'd57,  8'd51,
    8'd56,  8'd55,  8'd64,  8'd72,  8'd92,  8'd78,  8'd64,  8'd68,
    8'd87,  8'd69,  8'd55,  8'd56,  8'd80,  8'd109, 8'd81,  8'd87,
    8'd95,  8'd98,  8'd103, 8'd104, 8'd103, 8'd62,  8'd77,  8'd113,
    8'd121, 8'd112, 8'd100, 8'd120, 8'd92,  8'd101, 8'd103, 8'd99
  };

  localparam logic [7:0] Q_CHROMA [BLOCK_SIZE] = '{
    8'd17, 8'd18, 8'd18, 8'd24, 8'd21, 8'd24, 8'd47, 8'd26,
    8'd26, 8'd47, 8'd99, 8'd66, 8'd56, 8'd66, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  typedef struct packed {
    logic [5:0]                    run;
    logic signed [SYM_VALUE_W-1:0] value;
    logic                          dc;
    logic                          eob;
    logic                          last;
    logic                          valid;
  } rleSym_t;

  // round(65536 / q); only ever evaluated on constant table entries
  function automatic logic [16:0] recip17(input logic [7:0] q);
    logic [31:0] num;
    num = 32'd65536 + {25'd0, q[7:1]};
    return 17'(num / {24'd0, q});
  endfunction

endpackage

// File: rtl/quant_mul.sv
// Three-stage sign/magnitude reciprocal multiply with round-half-away-from-zero;
// the coefficient index and a valid bit travel alongside the data.
module quant_mul
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int OUT_WIDTH  = DATA_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic [5:0]            k_i,
  input  logic [16:0]           recip_i,
  output logic [OUT_WIDTH-1:0]  q_o,
  output logic [5:0]            k_o,
  output logic                  valid_o
);

  localparam int PROD_W     = DATA_WIDTH + 17;
  localparam int ROUND_HALF = 1 << (RECIP_SHIFT - 1);

  logic                  valid1_q, valid2_q, valid3_q;
  logic [5:0]            k1_q, k2_q, k3_q;
  logic                  sign1_q, sign2_q;
  logic [DATA_WIDTH-1:0] mag1_q, mag1_d;
  logic [16:0]           recip1_q;
  logic [PROD_W-1:0]     prod2_q, prod2_d;
  logic [PROD_W:0]       rounded;
  logic [OUT_WIDTH-1:0]  qMag;
  logic [OUT_WIDTH-1:0]  q3_q, q3_d;

  // The most negative input maps to a magnitude that still fits unsigned
  assign mag1_d  = data_i[DATA_WIDTH-1] ? -data_i : data_i;
  assign prod2_d = PROD_W'(mag1_q) * PROD_W'(recip1_q);
  assign rounded = {1'b0, prod2_q} + (PROD_W + 1)'(ROUND_HALF);
  assign qMag    = OUT_WIDTH'(rounded >> RECIP_SHIFT);
  assign q3_d    = sign2_q ? -qMag : qMag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
      valid3_q <= 1'b0;
      k1_q     <= '0;
      k2_q     <= '0;
      k3_q     <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      mag1_q   <= '0;
      recip1_q <= '0;
      prod2_q  <= '0;
      q3_q     <= '0;
    end else begin
      valid1_q <= valid_i;
      k1_q     <= k_i;
      sign1_q  <= data_i[DATA_WIDTH-1];
      mag1_q   <= mag1_d;
      recip1_q <= recip_i;
      valid2_q <= valid1_q;
      k2_q     <= k1_q;
      sign2_q  <= sign1_q;
      prod2_q  <= prod2_d;
      valid3_q <= valid2_q;
      k3_q     <= k2_q;
      q3_q     <= q3_d;
    end
  end

  assign q_o     = q3_q;
  assign k_o     = k3_q;
  assign valid_o = valid3_q;

endmodule

// File: rtl/quant_rle.sv
// Quantizer plus AC zero run-length coder for one zigzag-ordered 8x8 block lane.
// Define QUANT_RLE_DPCM_EN to emit the DC term as a difference from the previous block.
module quant_rle
  import jpeg_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int TABLE_SEL  = 0,
  parameter int OUT_WIDTH  = DATA_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [5:0]            out_run,
  output logic [OUT_WIDTH-1:0]  out_value,
  output logic                  out_dc,
  output logic                  out_eob,
  output logic                  out_last,
  output logic                  out_valid
);

  localparam logic [5:0] LAST_K = 6'(BLOCK_SIZE - 1);

  logic [5:0]                  k_q, k_d;
  logic [5:0]                  run_q, run_d;
  logic [16:0]                 recipRom [BLOCK_SIZE];
  logic signed [OUT_WIDTH-1:0] mulQ;
  logic signed [OUT_WIDTH-1:0] dcValue;
  logic [5:0]                  mulK;
  logic                        mulValid;
  rleSym_t                     sym;

  for (genvar i = 0; i < BLOCK_SIZE; i++) begin : g_recip
    assign recipRom[i] = recip17((TABLE_SEL == 1) ? Q_CHROMA[i] : Q_LUMA[i]);
  end

  assign k_d = in_valid ? k_q + 6'd1 : k_q;

  quant_mul #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .data_i (in_data),
    .valid_i(in_valid),
    .k_i    (k_q),
    .recip_i(recipRom[k_q]),
    .q_o    (mulQ),
    .k_o    (mulK),
    .valid_o(mulValid)
  );

`ifdef QUANT_RLE_DPCM_EN
  logic signed [OUT_WIDTH-1:0] pred_q, pred_d;

  assign dcValue = mulQ - pred_q;
  assign pred_d  = (mulValid && mulK == '0) ? mulQ : pred_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pred_q <= '0;
    else        pred_q <= pred_d;
  end
`else
  assign dcValue = mulQ;
`endif

  // Symbol decision on the quantized stage; the run resets at every emitted symbol
  always_comb begin
    sym   = '0;
    run_d = run_q;
    if (mulValid) begin
      if (mulK == '0) begin
        sym.valid = 1'b1;
        sym.dc    = 1'b1;
        sym.value = SYM_VALUE_W'(dcValue);
        run_d     = '0;
      end else if (mulQ != '0) begin
        sym.valid = 1'b1;
        sym.run   = run_q;
        sym.value = SYM_VALUE_W'(mulQ);
        sym.last  = (mulK == LAST_K);
        run_d     = '0;
      end else if (mulK == LAST_K) begin
        sym.valid = 1'b1;
        sym.eob   = 1'b1;
        sym.last  = 1'b1;
        run_d     = '0;
      end else begin
        run_d = run_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q   <= '0;
      run_q <= '0;
    end else begin
      k_q   <= k_d;
      run_q <= run_d;
    end
  end

  assign out_run   = sym.run;
  assign out_value = OUT_WIDTH'(sym.value);
  assign out_dc    = sym.dc;
  assign out_eob   = sym.eob;
  assign out_last  = sym.last;
  assign out_valid = sym.valid;

endmodule

// File: tb/tb_quant_rle.sv
// Scoreboard bench for quant_rle: the driver queues expected symbols with their
// due cycle, and a negedge monitor pops and compares whenever out_valid is seen.
module tb_quant_rle;

  localparam int DW = 10;
  localparam int OW = 11;

  typedef struct {
    int run;
    int value;
    bit dc;
    bit eob;
    bit last;
    int cyc;
  } expSym_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [DW-1:0] in_data;
  logic                 in_valid;
  logic [5:0]           out_run;
  logic signed [OW-1:0] out_value;
  logic                 out_dc, out_eob, out_last, out_valid;

  int      cycle      = 0;
  int      driveCycle = 0;
  int      errors     = 0;
  int      checks     = 0;
  int      predModel  = 0;
  expSym_t expQ[$];

  // Annex K luminance table in natural raster order, and the zigzag scan
  int lumaNat [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
  int zigzag [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  quant_rle #(
    .DATA_WIDTH(DW),
    .TABLE_SEL (0),
    .OUT_WIDTH (OW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_run  (out_run),
    .out_value(out_value),
    .out_dc   (out_dc),
    .out_eob  (out_eob),
    .out_last (out_last),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int quantModel(input int data, input int k);
    int qt, recip, mag, qm;
    qt    = lumaNat[zigzag[k]];
    recip = (65536 + qt / 2) / qt;
    mag   = (data < 0) ? -data : data;
    qm    = (mag * recip + 32768) / 65536;
    return (data < 0) ? -qm : qm;
  endfunction

  function automatic int dcExp(input int q0);
`ifdef QUANT_RLE_DPCM_EN
    int d;
    d         = q0 - predModel;
    predModel = q0;
    return d;
`else
    return q0;
`endif
  endfunction

  task automatic applyStimulus(input int data, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_data    = DW'(data);
    in_valid   = 1'b1;
    driveCycle = cycle;
  endtask

  task automatic pushSym(input int run, input int value, input bit dc, input bit eob, input bit last);
    expSym_t e;
    e.run   = run;
    e.value = value;
    e.dc    = dc;
    e.eob   = eob;
    e.last  = last;
    e.cyc   = driveCycle + 3;
    expQ.push_back(e);
  endtask

  // qv holds the hand-computed quantized value of each coefficient
  task automatic sendBlock(input int coef[64], input int qv[64], input int maxGap);
    int run;
    run = 0;
    for (int k = 0; k < 64; k++) begin
      applyStimulus(coef[k], (maxGap > 0 && k > 0) ? int'($urandom_range(0, maxGap)) : 0);
      if (k == 0) begin
        pushSym(0, dcExp(qv[0]), 1'b1, 1'b0, 1'b0);
      end else if (k == 63) begin
        if (qv[k] != 0) pushSym(run, qv[k], 1'b0, 1'b0, 1'b1);
        else            pushSym(0, 0, 1'b0, 1'b1, 1'b1);
      end else if (qv[k] == 0) begin
        run++;
      end else begin
        pushSym(run, qv[k], 1'b0, 1'b0, 1'b0);
        run = 0;
      end
    end
  endtask

  task automatic checkOutput(input expSym_t e);
    checks++;
    if (int'(out_run) != e.run || int'(out_value) != e.value || out_dc !== e.dc ||
        out_eob !== e.eob || out_last !== e.last) begin
      errors++;
      $display("[TB] FAIL symbol_fields cycle=%0d got run=%0d value=%0d dc=%0b eob=%0b last=%0b required run=%0d value=%0d dc=%0b eob=%0b last=%0b",
               cycle, out_run, out_value, out_dc, out_eob, out_last, e.run, e.value, e.dc, e.eob, e.last);
    end
    checks++;
    if (cycle != e.cyc) begin
      errors++;
      $display("[TB] FAIL symbol_latency got cycle=%0d required cycle=%0d", cycle, e.cyc);
    end
  endtask

  task automatic checkIdle(input string name);
    checks++;
    if ({out_valid, out_dc, out_eob, out_last, out_run, out_value} !== '0) begin
      errors++;
      $display("[TB] FAIL %s got valid=%0b dc=%0b eob=%0b last=%0b run=%0d value=%0d required all zero",
               name, out_valid, out_dc, out_eob, out_last, out_run, out_value);
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain got %0d symbols outstanding required 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  always @(negedge clk) begin
    expSym_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_symbol cycle=%0d got run=%0d value=%0d dc=%0b eob=%0b last=%0b required no symbol",
                 cycle, out_run, out_value, out_dc, out_eob, out_last);
      end else begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    int coef[64];
    int qv[64];

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    checkIdle("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    checkIdle("idle_after_reset");

    // Back-to-back blocks, DC 160 then 96
    foreach (coef[i]) begin coef[i] = 0; qv[i] = 0; end
    coef[0] = 160; qv[0] = 10;
    sendBlock(coef, qv, 0);
    coef[0] = 96;  qv[0] = 6;
    sendBlock(coef, qv, 0);
    waitDrain("back_to_back");

    // DC only: 100 / 16 -> 6, then EOB
    coef[0] = 100; qv[0] = 6;
    sendBlock(coef, qv, 0);
    waitDrain("dc_only");

    // Zero DC still emitted; 62-zero run ending on a nonzero last coefficient
    coef[0] = 0;   qv[0] = 0;
    coef[63] = 511; qv[63] = 5;
    sendBlock(coef, qv, 0);
    waitDrain("long_run");

    // Negative rounding and short runs
    foreach (coef[i]) begin coef[i] = 0; qv[i] = 0; end
    coef[0] = -24; qv[0] = -2;
    coef[4] = 511; qv[4] = 43;
    coef[5] = 511; qv[5] = 51;
    sendBlock(coef, qv, 0);
    waitDrain("neg_round");

    // All coefficients +200: every symbol has run 0, no EOB
    foreach (coef[i]) begin coef[i] = 200; qv[i] = quantModel(200, i); end
    sendBlock(coef, qv, 0);
    waitDrain("all_nonzero");

    // Same block as the rounding case but with random input gaps
    foreach (coef[i]) begin coef[i] = 0; qv[i] = 0; end
    coef[0] = -24; qv[0] = -2;
    coef[4] = 511; qv[4] = 43;
    coef[5] = 511; qv[5] = 51;
    sendBlock(coef, qv, 3);
    waitDrain("gaps");

    // Reset after 30 coefficients; the in-flight coefficient 29 must vanish
    applyStimulus(100, 0);
    pushSym(0, dcExp(6), 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 29; k++) applyStimulus(0, 0);
    applyStimulus(511, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkIdle("mid_block_reset");
    @(negedge clk);
    checkIdle("mid_block_reset_hold");
    predModel = 0;
    rst_n     = 1'b1;
    coef[0] = 160; qv[0] = 10;
    sendBlock(coef, qv, 0);
    waitDrain("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
